// File: rtl/lsu_ctrl.sv
// Load/store unit controller: validates an EX/MEM access, runs a single-request
// memory handshake with a watchdog, and formats load data for MEM/WB.
module lsu_ctrl #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic [31:0] mem_rdata,
  output logic        stall,
  output logic        mem_fault
);

  localparam int unsigned WD_W = 16;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WAIT_MAX - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [WD_W-1:0] wd_q;
  logic            we_q;
  logic [29:0]     waddr_q;
  logic [1:0]      off_q;
  logic [2:0]      f3_q;
  logic [3:0]      wstrb_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            fault_q;

  logic            any_c, legal_c, f3_ok_c, align_ok_c;
  logic [3:0]      st_wstrb_c;
  logic [31:0]     st_wdata_c;
  logic            start_c, load_done_c, fault_c, wd_exp_c;

  // Select and extend the addressed byte/halfword of a raw read word.
  function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Access legality and store lane placement for the incoming request.
  always_comb begin
    any_c      = memread_in | memwrite_in;
    f3_ok_c    = 1'b0;
    align_ok_c = 1'b1;
    st_wstrb_c = 4'b0000;
    st_wdata_c = 32'd0;
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_ok_c = 1'b1;
      3'b100, 3'b101:         f3_ok_c = ~memwrite_in;
      default:                f3_ok_c = 1'b0;
    endcase
    case (funct3[1:0])
      2'b01:   align_ok_c = ~addr[0];
      2'b10:   align_ok_c = (addr[1:0] == 2'b00);
      default: align_ok_c = 1'b1;
    endcase
    legal_c = ~(memread_in & memwrite_in) & f3_ok_c & align_ok_c;
    if (memwrite_in) begin
      case (funct3[1:0])
        2'b00: begin
          st_wstrb_c = 4'b0001 << addr[1:0];
          st_wdata_c = {4{wdata[7:0]}};
        end
        2'b01: begin
          st_wstrb_c = addr[1] ? 4'b1100 : 4'b0011;
          st_wdata_c = {2{wdata[15:0]}};
        end
        default: begin
          st_wstrb_c = 4'b1111;
          st_wdata_c = wdata;
        end
      endcase
    end
  end

  // Next-state and handshake decisions; a grant beats watchdog expiry.
  always_comb begin
    state_d     = state_q;
    start_c     = 1'b0;
    load_done_c = 1'b0;
    fault_c     = 1'b0;
    wd_exp_c    = (wd_q >= WD_LAST);
    case (state_q)
      S_IDLE: begin
        if (any_c) begin
          if (legal_c) begin
            state_d = S_REQ;
            start_c = 1'b1;
          end else begin
            fault_c = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (dm_gnt) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (wd_exp_c) begin
          state_d = S_DONE;
          fault_c = 1'b1;
        end
      end
      S_WAIT: begin
        if (dm_rvalid) begin
          state_d     = S_DONE;
          load_done_c = 1'b1;
        end else if (wd_exp_c) begin
          state_d = S_DONE;
          fault_c = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Watchdog, latched access fields, load result and fault pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_c;
      if (start_c) begin
        wd_q    <= '0;
        we_q    <= memwrite_in;
        waddr_q <= addr[31:2];
        off_q   <= addr[1:0];
        f3_q    <= funct3;
        wstrb_q <= st_wstrb_c;
        wdata_q <= st_wdata_c;
      end else if (state_q == S_REQ || state_q == S_WAIT) begin
        wd_q <= wd_q + WD_W'(1);
      end
      if (load_done_c) rdata_q <= fmt_load(f3_q, off_q, dm_rdata);
    end
  end

  assign dm_req    = (state_q == S_REQ);
  assign dm_we     = we_q;
  assign dm_addr   = {waddr_q, 2'b00};
  assign dm_wstrb  = wstrb_q;
  assign dm_wdata  = wdata_q;
  assign mem_rdata = rdata_q;
  assign mem_fault = fault_q;
  assign stall     = (state_q == S_REQ) || (state_q == S_WAIT) ||
                     ((state_q == S_IDLE) && any_c && legal_c);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a short watchdog.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memread_in = 1'b0, memwrite_in = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_gnt = 1'b0, dm_rvalid = 1'b0;
  logic [31:0] dm_rdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        stall, mem_fault;

  int checks = 0;
  int failures = 0;

  lsu_ctrl #(.WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .memread_in(memread_in), .memwrite_in(memwrite_in),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_rdata(mem_rdata), .stall(stall), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    memread_in  = 1'b0;
    memwrite_in = 1'b0;
    funct3      = 3'd0;
    addr        = 32'd0;
    wdata       = 32'd0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},   32'(dm_req),    32'd0);
    chk({tag, "_we"},    32'(dm_we),     32'd0);
    chk({tag, "_addr"},  dm_addr,        32'd0);
    chk({tag, "_wstrb"}, 32'(dm_wstrb),  32'd0);
    chk({tag, "_wdata"}, dm_wdata,       32'd0);
    chk({tag, "_rdata"}, mem_rdata,      32'd0);
    chk({tag, "_fault"}, 32'(mem_fault), 32'd0);
    chk({tag, "_stall"}, 32'(stall),     32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #3;
    check_all_zero("rst");
    rst = 1'b1;
    tick();

    // LB 0x1003, gnt in first REQ cycle, rvalid two cycles later
    memread_in = 1'b1; funct3 = 3'b000; addr = 32'h0000_1003;
    #1 chk("lb_stall_idle", 32'(stall), 32'd1);
    tick();
    idle_inputs();
    chk("lb_req", 32'(dm_req), 32'd1);
    chk("lb_addr", dm_addr, 32'h0000_1000);
    chk("lb_we", 32'(dm_we), 32'd0);
    chk("lb_wstrb", 32'(dm_wstrb), 32'd0);
    chk("lb_wdata", dm_wdata, 32'd0);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    chk("lb_wait_req", 32'(dm_req), 32'd0);
    chk("lb_wait_stall", 32'(stall), 32'd1);
    tick();
    dm_rvalid = 1'b1; dm_rdata = 32'h8011_2233;
    tick();
    dm_rvalid = 1'b0;
    chk("lb_rdata", mem_rdata, 32'hFFFF_FF80);
    chk("lb_done_stall", 32'(stall), 32'd0);
    chk("lb_done_fault", 32'(mem_fault), 32'd0);
    tick();

    // SH 0x2002, gnt held high
    memwrite_in = 1'b1; funct3 = 3'b001; addr = 32'h0000_2002; wdata = 32'h0000_BEEF;
    dm_gnt = 1'b1;
    #1 chk("sh_stall_idle", 32'(stall), 32'd1);
    tick();
    idle_inputs();
    chk("sh_req", 32'(dm_req), 32'd1);
    chk("sh_we", 32'(dm_we), 32'd1);
    chk("sh_addr", dm_addr, 32'h0000_2000);
    chk("sh_wstrb", 32'(dm_wstrb), 32'hC);
    chk("sh_wdata", dm_wdata, 32'hBEEF_BEEF);
    chk("sh_stall_req", 32'(stall), 32'd1);
    tick();
    dm_gnt = 1'b0;
    chk("sh_done_req", 32'(dm_req), 32'd0);
    chk("sh_done_stall", 32'(stall), 32'd0);
    chk("sh_keeps_rdata", mem_rdata, 32'hFFFF_FF80);
    tick();

    // LW misaligned 0x3001
    memread_in = 1'b1; funct3 = 3'b010; addr = 32'h0000_3001;
    #1 chk("lwmis_stall", 32'(stall), 32'd0);
    tick();
    idle_inputs();
    chk("lwmis_fault", 32'(mem_fault), 32'd1);
    chk("lwmis_req", 32'(dm_req), 32'd0);
    chk("lwmis_rdata", mem_rdata, 32'hFFFF_FF80);
    tick();
    chk("lwmis_fault_clr", 32'(mem_fault), 32'd0);

    // Watchdog: LH with no grant, WAIT_MAX = 4
    memread_in = 1'b1; funct3 = 3'b001; addr = 32'h0000_5000;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wd_req_%0d", i), 32'(dm_req), 32'd1);
      chk($sformatf("wd_stall_%0d", i), 32'(stall), 32'd1);
      if (i < 3) tick();
    end
    tick();
    chk("wd_done_req", 32'(dm_req), 32'd0);
    chk("wd_done_fault", 32'(mem_fault), 32'd1);
    chk("wd_done_stall", 32'(stall), 32'd0);
    chk("wd_rdata", mem_rdata, 32'hFFFF_FF80);
    tick();
    chk("wd_idle_fault", 32'(mem_fault), 32'd0);
    chk("wd_idle_req", 32'(dm_req), 32'd0);

    // LHU 0x4002 then LBU 0x4002 on 0x9ABC0000
    memread_in = 1'b1; funct3 = 3'b101; addr = 32'h0000_4002; dm_gnt = 1'b1;
    tick();
    idle_inputs();
    tick();
    dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h9ABC_0000;
    tick();
    dm_rvalid = 1'b0;
    chk("lhu_rdata", mem_rdata, 32'h0000_9ABC);
    tick();
    memread_in = 1'b1; funct3 = 3'b100; addr = 32'h0000_4002; dm_gnt = 1'b1;
    tick();
    idle_inputs();
    tick();
    dm_gnt = 1'b0; dm_rvalid = 1'b1;
    tick();
    dm_rvalid = 1'b0;
    chk("lbu_rdata", mem_rdata, 32'h0000_00BC);
    tick();

    // SB 0x6001 lanes
    memwrite_in = 1'b1; funct3 = 3'b000; addr = 32'h0000_6001; wdata = 32'h1234_5678;
    dm_gnt = 1'b1;
    tick();
    idle_inputs();
    chk("sb_wstrb", 32'(dm_wstrb), 32'h2);
    chk("sb_wdata", dm_wdata, 32'h7878_7878);
    tick();
    dm_gnt = 1'b0;
    tick();

    // SW 0x6004, grant arrives in the expiry cycle and wins
    memwrite_in = 1'b1; funct3 = 3'b010; addr = 32'h0000_6004; wdata = 32'h1234_5678;
    tick();
    idle_inputs();
    chk("sw_wstrb", 32'(dm_wstrb), 32'hF);
    chk("sw_wdata", dm_wdata, 32'h1234_5678);
    tick();
    tick();
    tick();
    chk("sw_last_req", 32'(dm_req), 32'd1);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    chk("sw_gnt_wins_fault", 32'(mem_fault), 32'd0);
    chk("sw_done_req", 32'(dm_req), 32'd0);
    tick();

    // Illegal: both read and write
    memread_in = 1'b1; memwrite_in = 1'b1; funct3 = 3'b010; addr = 32'h0000_8000;
    #1 chk("both_stall", 32'(stall), 32'd0);
    tick();
    idle_inputs();
    chk("both_fault", 32'(mem_fault), 32'd1);
    chk("both_req", 32'(dm_req), 32'd0);
    tick();

    // Illegal: store with funct3 100
    memwrite_in = 1'b1; funct3 = 3'b100; addr = 32'h0000_8000;
    tick();
    idle_inputs();
    chk("sbu_fault", 32'(mem_fault), 32'd1);
    chk("sbu_req", 32'(dm_req), 32'd0);
    tick();

    // Reset during WAIT, then late rvalid
    memread_in = 1'b1; funct3 = 3'b000; addr = 32'h0000_7003; dm_gnt = 1'b1;
    tick();
    idle_inputs();
    tick();
    dm_gnt = 1'b0;
    chk("rw_in_wait", 32'(stall), 32'd1);
    rst = 1'b0;
    #1 check_all_zero("rw_async");
    tick();
    rst = 1'b1;
    dm_rvalid = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    tick();
    dm_rvalid = 1'b0;
    check_all_zero("rw_late");
    tick();
    chk("rw_late2_rdata", mem_rdata, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter WAIT_MAX, 255, max cycles spent in REQ or WAIT before abort (range 1..65535).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 memread_in  input  1  load request from EX/MEM stage.
REQ-005 memwrite_in  input  1  store request from EX/MEM stage.
REQ-006 funct3  input  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data, right-aligned.
REQ-009 dm_req  output  1  memory request valid.
REQ-010 dm_we  output  1  1 = write, 0 = read.
REQ-011 dm_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-012 dm_wstrb  output  4  byte write enables.
REQ-013 dm_wdata  output  32  lane-aligned store data.
REQ-014 dm_gnt  input  1  memory accepts request this cycle.
REQ-015 dm_rvalid  input  1  read data valid.
REQ-016 dm_rdata  input  32  raw read word.
REQ-017 mem_rdata  output  32  formatted load data to MEM/WB.
REQ-018 stall  output  1  freeze IF..EX/MEM while high.
REQ-019 mem_fault  output  1  one-cycle pulse, access not performed or aborted.

Function
REQ-020 FSM states IDLE, REQ, WAIT, DONE; one state register.
REQ-021 IDLE: valid access (exactly one of memread_in/memwrite_in, legal funct3, aligned) -> REQ next cycle; no valid access -> stay IDLE.
REQ-022 Illegal access: both memread_in and memwrite_in high, or store funct3 not 000/001/010, or load funct3 011/110/111, or halfword with addr[0]=1, or word with addr[1:0]!=0 -> mem_fault high for the next cycle, no dm_req, stay IDLE.
REQ-023 Access fields (we, addr, wstrb, wdata, funct3, addr[1:0]) latched on IDLE->REQ; dm_* driven from latched copy, stable while dm_req=1 and dm_gnt=0.
REQ-024 REQ: dm_req=1; dm_gnt=1 with store -> DONE; dm_gnt=1 with load -> WAIT.
REQ-025 WAIT: dm_req=0; dm_rvalid=1 -> capture formatted dm_rdata into mem_rdata, -> DONE.
REQ-026 dm_rvalid outside WAIT ignored.
REQ-027 DONE: lasts exactly one cycle, stall=0, then -> IDLE unconditionally; no request issued from DONE.
REQ-028 stall = 1 in REQ and WAIT, and in IDLE when a valid access is presented; 0 in DONE, in IDLE with no or illegal access.
REQ-029 Store lanes: SB wstrb=4'b0001<<addr[1:0], wdata byte replicated to all 4 lanes; SH wstrb=4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1), halfword replicated; SW wstrb=4'b1111, wdata unchanged.
REQ-030 dm_wstrb=0 and dm_wdata=0 for loads.
REQ-031 Load format: LB/LBU select byte addr[1:0], LH/LHU select half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW passes word.
REQ-032 mem_rdata holds its value until next completed load; stores and faults do not change it.
REQ-033 Watchdog counter, 16 bits, cleared on entry to REQ, increments each cycle in REQ/WAIT, not cleared REQ->WAIT; reaching WAIT_MAX with no gnt/rvalid -> mem_fault pulse, dm_req dropped, -> DONE, mem_rdata unchanged.
REQ-034 dm_gnt and watchdog expiry in same cycle: gnt wins.
REQ-035 Back-to-back accesses: new access sampled in IDLE the cycle after DONE; minimum store latency 3 cycles (IDLE, REQ, DONE).

Reset
REQ-036 rst=0 asynchronously forces IDLE, watchdog 0, latched fields 0, mem_rdata=0, dm_req=0, dm_we=0, dm_addr=0, dm_wstrb=0, dm_wdata=0, mem_fault=0; stall=0 unless valid access presented.
REQ-037 Reset mid-REQ/WAIT aborts access; late dm_rvalid after reset release ignored.

Verification
REQ-038 LB addr=0x1003, dm_gnt next cycle, dm_rvalid 2 cycles later with 0x80112233 -> dm_addr=0x1000, mem_rdata=0xFFFFFF80, stall low in DONE.
REQ-039 SH addr=0x2002 wdata=0x0000BEEF, dm_gnt immediate -> dm_wstrb=4'b1100, dm_wdata=0xBEEFBEEF, stall exactly 2 cycles.
REQ-040 LW addr=0x3001 -> no dm_req, mem_fault 1 cycle, stall 0, mem_rdata unchanged.
REQ-041 WAIT_MAX=4, load with dm_gnt held 0 -> dm_req drops after 4 REQ cycles, mem_fault pulse, FSM DONE then IDLE.
REQ-042 LHU addr=0x4002 rdata 0x9ABC0000 -> mem_rdata=0x00009ABC; LBU addr=0x4002 same rdata -> 0x000000BC.
REQ-043 rst low during WAIT, then dm_rvalid after release -> all outputs 0, FSM IDLE, mem_rdata stays 0.
